sevenseg_scan_mux: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display.
//  - Takes packed BCD/hex nibbles and scans one digit per dwell period.
//  - Adds tear-free frame-synchronous updates, per-digit blanking, decimal points and anti-ghost guard time.
//  - Sits between the counter/display logic and the board's PMOD/on-board display pins.

---
 rtl/sevenseg_pkg.sv | 57 +++++
 rtl/sevenseg_scan_mux_if.sv | 36 +++
 rtl/sevenseg_decoder.sv | 10 +
 rtl/sevenseg_scan_mux.sv | 144 ++++++++++++++
 tb/tb_sevenseg_scan_mux.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Segment patterns and nibble decode for the seven-segment scan driver.
// Bit order is {a,b,c,d,e,f,g}; patterns are active-high (1 = lit).
package sevenseg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_0   = 7'h7E;
  localparam logic [6:0] SEG_1   = 7'h30;
  localparam logic [6:0] SEG_2   = 7'h6D;
  localparam logic [6:0] SEG_3   = 7'h79;
  localparam logic [6:0] SEG_4   = 7'h33;
  localparam logic [6:0] SEG_5   = 7'h5B;
  localparam logic [6:0] SEG_6   = 7'h5F;
  localparam logic [6:0] SEG_7   = 7'h70;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h7B;
  localparam logic [6:0] SEG_A_H = 7'h77;
  localparam logic [6:0] SEG_B_H = 7'h1F;
  localparam logic [6:0] SEG_C_H = 7'h4E;
  localparam logic [6:0] SEG_D_H = 7'h3D;
  localparam logic [6:0] SEG_E_H = 7'h4F;
  localparam logic [6:0] SEG_F_H = 7'h47;

  function automatic logic [6:0] seg_pattern(
    input logic [3:0] nib
  );
    logic [6:0] p;
    p = SEG_OFF;
    unique case (nib)
      4'h0: p = SEG_0;
      4'h1: p = SEG_1;
      4'h2: p = SEG_2;
      4'h3: p = SEG_3;
      4'h4: p = SEG_4;
      4'h5: p = SEG_5;
      4'h6: p = SEG_6;
      4'h7: p = SEG_7;
      4'h8: p = SEG_8;
      4'h9: p = SEG_9;
      4'hA: p = SEG_A_H;
      4'hB: p = SEG_B_H;
      4'hC: p = SEG_C_H;
      4'hD: p = SEG_D_H;
      4'hE: p = SEG_E_H;
      4'hF: p = SEG_F_H;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sevenseg_scan_mux_if.sv
// Display data and pin bundle of the seven-segment scan driver.
// master = display-data source, slave = scan driver.
interface sevenseg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              cathode;
  logic                    dp_out;
  logic                    frame_done;

  modport master (
    output digits_in,
    output dp_in,
    output blank_in,
    output load,
    input  anode,
    input  cathode,
    input  dp_out,
    input  frame_done
  );

  modport slave (
    input  digits_in,
    input  dp_in,
    input  blank_in,
    input  load,
    output anode,
    output cathode,
    output dp_out,
    output frame_done
  );
endinterface

// File: rtl/sevenseg_decoder.sv
// Combinational nibble to active-high {a..g} segment pattern.
// Pure lookup; polarity is handled by the caller.
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);
  assign pattern = seg_pattern(nibble);
endmodule

// File: rtl/sevenseg_scan_mux.sv
// N-digit seven-segment scan driver with frame-synchronous updates.
// Define SEVENSEG_LZ_BLANK_EN to enable leading-zero suppression.
module sevenseg_scan_mux
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int DWELL_CYCLES  = 65536,
  parameter int GUARD_CYCLES  = 256,
  parameter bit ANODE_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW   = 1'b1
) (
  input  logic clock_in,
  input  logic reset_n,
  sevenseg_scan_mux_if.slave bus
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW =
    (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST =
    PW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST =
    IW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    {NUM_DIGITS{ANODE_ACT_LOW}};
  localparam logic [6:0] SEG_LVL =
    {7{SEG_ACT_LOW}};

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;

  logic [DW-1:0]         pend_digits;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pend_flag;

  logic [DW-1:0]         sh_digits;
  logic [NUM_DIGITS-1:0] sh_dp;
  logic [NUM_DIGITS-1:0] sh_blank;

  logic [NUM_DIGITS-1:0] anode_q;
  logic [6:0]            cathode_q;
  logic                  dp_q;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            cur_nib;
  logic [6:0]            pat;
  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] sel;
  logic                  dark;
  logic                  guard;

  assign slot_end  = (presc == P_LAST);
  assign frame_end = slot_end && (idx == I_LAST);

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      presc       <= '0;
      idx         <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_flag   <= 1'b0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
    end else begin
      presc <= slot_end ? '0 : presc + PW'(1);
      if (slot_end) begin
        idx <= (idx == I_LAST) ? '0 : idx + IW'(1);
      end
      // shadow only moves at the frame boundary
      if (frame_end) begin
        if (bus.load) begin
          sh_digits <= bus.digits_in;
          sh_dp     <= bus.dp_in;
          sh_blank  <= bus.blank_in;
        end else if (pend_flag) begin
          sh_digits <= pend_digits;
          sh_dp     <= pend_dp;
          sh_blank  <= pend_blank;
        end
        pend_flag <= 1'b0;
      end else if (bus.load) begin
        pend_digits <= bus.digits_in;
        pend_dp     <= bus.dp_in;
        pend_blank  <= bus.blank_in;
        pend_flag   <= 1'b1;
      end
    end
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  logic seen;
  always_comb begin
    lz   = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (sh_digits[4*k +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      lz[k] = !seen;
    end
  end
`else
  assign lz = '0;
`endif

  assign cur_nib = sh_digits[4*idx +: 4];

  sevenseg_decoder u_dec (
    .nibble  (cur_nib),
    .pattern (pat)
  );

  assign dark  = sh_blank[idx] | lz[idx];
  assign guard = int'(presc) < GUARD_CYCLES;
  assign sel   = NUM_DIGITS'(1) << idx;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      anode_q   <= AN_OFF;
      cathode_q <= SEG_LVL;
      dp_q      <= SEG_ACT_LOW;
    end else begin
      anode_q   <= ((dark || guard) ? '0 : sel)
                   ^ AN_OFF;
      cathode_q <= (dark ? SEG_OFF : pat) ^ SEG_LVL;
      dp_q      <= (sh_dp[idx] & !dark)
                   ^ SEG_ACT_LOW;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.cathode    = cathode_q;
  assign bus.dp_out     = dp_q;
  assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Randomized self-checking bench for sevenseg_scan_mux (4 digits,
// dwell 8, guard 2, active-low pins) against a cycle-count model.
module tb_sevenseg_scan_mux;

  localparam int N = 4;
  localparam int D = 8;
  localparam int G = 2;
  localparam int FR = N * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_mux_if #(.NUM_DIGITS(N)) bus ();

  sevenseg_scan_mux #(
    .NUM_DIGITS    (N),
    .DWELL_CYCLES  (D),
    .GUARD_CYCLES  (G),
    .ANODE_ACT_LOW (1'b1),
    .SEG_ACT_LOW   (1'b1)
  ) dut (
    .clock_in (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [6:0] pat_tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: c = non-reset cycles since reset; slot = (c/D)%N, phase = c%D
  int c;
  logic [15:0] m_dig, p_dig;
  logic [3:0]  m_dp, m_bl, p_dp, p_bl;
  bit          p_flag;
  logic [3:0]  e_an;
  logic [6:0]  e_cat;
  logic        e_dp, e_fd;

  function automatic logic [3:0] eff_blank(
    input logic [15:0] d, input logic [3:0] b);
    logic [3:0] r;
    r = b;
`ifdef SEVENSEG_LZ_BLANK_EN
    for (int k = 1; k < N; k++)
      if ((d >> (4 * k)) == 16'd0) r[k] = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [3:0] f_an(
    input int cc, input logic [15:0] d, input logic [3:0] b);
    int slot;
    logic [3:0] eb;
    logic [3:0] one;
    slot = (cc / D) % N;
    eb = eff_blank(d, b);
    one = 4'b0001;
    if ((cc % D) < G || eb[slot]) return 4'hF;
    return ~(one << slot);
  endfunction

  function automatic logic [6:0] f_cat(
    input int cc, input logic [15:0] d, input logic [3:0] b);
    int slot;
    logic [3:0] eb;
    slot = (cc / D) % N;
    eb = eff_blank(d, b);
    if (eb[slot]) return 7'h7F;
    return ~pat_tab[d[4*slot +: 4]];
  endfunction

  function automatic logic f_dp(
    input int cc, input logic [15:0] d,
    input logic [3:0] b, input logic [3:0] p);
    int slot;
    logic [3:0] eb;
    slot = (cc / D) % N;
    eb = eff_blank(d, b);
    return !(p[slot] && !eb[slot]);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      c <= 0;
      m_dig <= '0; m_dp <= '0; m_bl <= '0;
      p_dig <= '0; p_dp <= '0; p_bl <= '0;
      p_flag <= 1'b0;
      e_an <= 4'hF; e_cat <= 7'h7F;
      e_dp <= 1'b1; e_fd <= 1'b0;
    end else begin
      e_an  <= f_an(c, m_dig, m_bl);
      e_cat <= f_cat(c, m_dig, m_bl);
      e_dp  <= f_dp(c, m_dig, m_bl, m_dp);
      e_fd  <= ((c + 1) % FR) == FR - 1;
      c <= c + 1;
      if ((c % FR) == FR - 1) begin
        if (bus.load) begin
          m_dig <= bus.digits_in;
          m_dp  <= bus.dp_in;
          m_bl  <= bus.blank_in;
        end else if (p_flag) begin
          m_dig <= p_dig; m_dp <= p_dp; m_bl <= p_bl;
        end
        p_flag <= 1'b0;
      end else if (bus.load) begin
        p_dig <= bus.digits_in;
        p_dp  <= bus.dp_in;
        p_bl  <= bus.blank_in;
        p_flag <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_anode", 32'(bus.anode), 32'(e_an));
      check("m_cathode", 32'(bus.cathode), 32'(e_cat));
      check("m_dp_out", 32'(bus.dp_out), 32'(e_dp));
      check("m_frame_done", 32'(bus.frame_done), 32'(e_fd));
    end
  end

  task automatic do_load(input logic [15:0] d,
                         input logic [3:0] p,
                         input logic [3:0] b);
    bus.digits_in = d;
    bus.dp_in = p;
    bus.blank_in = b;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("fd_seen", 32'(bus.frame_done), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_anode"}, 32'(bus.anode), 32'hF);
    check({tag, "_cathode"}, 32'(bus.cathode), 32'h7F);
    check({tag, "_dp"}, 32'(bus.dp_out), 32'd1);
    check({tag, "_fd"}, 32'(bus.frame_done), 32'd0);
  endtask

  task automatic scan_frame(output logic [3:0] lit,
                            output logic [6:0] cat1,
                            output logic [6:0] cat0);
    lit = '0; cat1 = '0; cat0 = '0;
    repeat (FR) begin
      for (int k = 0; k < N; k++) begin
        if (!bus.anode[k]) begin
          lit[k] = 1'b1;
          if (k == 1) cat1 = bus.cathode;
          if (k == 0) cat0 = bus.cathode;
        end
      end
      @(negedge clk);
    end
  endtask

  time t0, t1;
  logic an2_low;
  int dp_cnt;
  logic [3:0] lit;
  logic [6:0] c1, c0;

  initial begin
    bus.digits_in = '0;
    bus.dp_in = '0;
    bus.blank_in = '0;
    bus.load = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("t1");
    rst_n = 1'b1;

    do_load(16'h4321, 4'h0, 4'h0);
    wait_fd();
    t0 = $time;
    repeat (2) @(negedge clk);
    check("t2_cat_d0", 32'(bus.cathode), 32'h4F);
    check("t2_guard", 32'(bus.anode), 32'hF);
    repeat (2) @(negedge clk);
    check("t2_anode_d0", 32'(bus.anode), 32'hE);

    do_load(16'h9999, 4'h0, 4'h0);
    @(negedge clk);
    check("t3_hold", 32'(bus.cathode), 32'h4F);
    wait_fd();
    t1 = $time;
    check("t2_fd_period", 32'((t1 - t0) / 10), 32'd32);
    do_load(16'h0005, 4'h1, 4'h0);
    @(negedge clk);
    check("t3_imm_cat", 32'(bus.cathode), 32'h24);
    check("t3_imm_dp", 32'(bus.dp_out), 32'd0);

    do_load(16'h4321, 4'b0001, 4'b0100);
    wait_fd();
    repeat (2) @(negedge clk);
    an2_low = 1'b0;
    dp_cnt = 0;
    repeat (2 * FR) begin
      if (!bus.anode[2]) an2_low = 1'b1;
      if (!bus.dp_out) dp_cnt++;
      @(negedge clk);
    end
    check("t4_an2_low", 32'(an2_low), 32'd0);
    check("t4_dp_cnt", 32'(dp_cnt), 32'd16);

    wait_fd();
    @(negedge clk);
    do_load(16'h8888, 4'h0, 4'h0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("t5");
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_restart_cat", 32'(bus.cathode), 32'h01);
    check("t5_restart_guard", 32'(bus.anode), 32'hF);
    repeat (2) @(negedge clk);
    check("t5_restart_d0", 32'(bus.anode), 32'hE);
    wait_fd();
    repeat (2) @(negedge clk);
    check("t5_pend_lost", 32'(bus.cathode), 32'h01);

    repeat (800) begin
      if ((bus.frame_done && ($urandom % 2 == 0)) ||
          ($urandom % 8 == 0)) begin
        bus.digits_in = 16'($urandom);
        bus.dp_in = 4'($urandom);
        bus.blank_in = 4'($urandom & $urandom);
        bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;

`ifdef SEVENSEG_LZ_BLANK_EN
    do_load(16'h0070, 4'h0, 4'h0);
    wait_fd();
    repeat (2) @(negedge clk);
    scan_frame(lit, c1, c0);
    check("t6_lit", 32'(lit), 32'b0011);
    check("t6_cat1", 32'(c1), 32'h0F);
    check("t6_cat0", 32'(c0), 32'h01);
    do_load(16'h0000, 4'h0, 4'h0);
    wait_fd();
    repeat (2) @(negedge clk);
    scan_frame(lit, c1, c0);
    check("t6_zero_lit", 32'(lit), 32'b0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout total=%0d bad=%0d",
             total, bad);
    $fatal(1, "timeout");
  end

endmodule
